// File: rtl/cx_dma_dispatch.sv
// cx_dma_dispatch: takes one DMA command at a time. It checks the command's
// address range for overlap with in-flight transfers (tracker lookup),
// allocates a tracker slot, and issues the transfer tagged with that slot.
// Engine completions go to the tracker remove port through a one-entry skid
// register, which keeps completions flowing at one per cycle.
// Optional build macro CX_DISPATCH_STATS_EN adds the o_retry_cnt and
// o_xfer_cnt statistics outputs.
module cx_dma_dispatch #(
  parameter int  DEPTH   = 8,
  parameter int  BACKOFF = 4,
  parameter int  DATA_W  = 32,
  parameter int  ID_W    = 4,
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
`ifdef CX_DISPATCH_STATS_EN
  output logic [31:0]       o_retry_cnt,
  output logic [31:0]       o_xfer_cnt,
`endif
  input  logic              s_cmd_valid,
  output logic              s_cmd_ready,
  input  logic [DATA_W-1:0] s_cmd_base,
  input  logic [DATA_W-1:0] s_cmd_end,
  input  logic              s_cmd_rw,
  input  logic [ID_W-1:0]   s_cmd_id,
  output logic              m_lkup_req_valid,
  input  logic              m_lkup_req_ready,
  output logic [DATA_W-1:0] m_lkup_req_base,
  output logic [DATA_W-1:0] m_lkup_req_end,
  output logic              m_lkup_req_rw,
  output logic [ID_W-1:0]   m_lkup_req_id,
  input  logic              s_lkup_resp_valid,
  output logic              s_lkup_resp_ready,
  input  logic              s_lkup_resp_data,
  input  logic [ID_W-1:0]   s_lkup_resp_id,
  output logic              m_alloc_req_valid,
  input  logic              m_alloc_req_ready,
  output logic [DATA_W-1:0] m_alloc_req_base,
  output logic [DATA_W-1:0] m_alloc_req_end,
  output logic              m_alloc_req_rw,
  input  logic              s_alloc_resp_valid,
  output logic              s_alloc_resp_ready,
  input  logic [IW-1:0]     s_alloc_resp_data,
  output logic              m_xfer_valid,
  input  logic              m_xfer_ready,
  output logic [DATA_W-1:0] m_xfer_base,
  output logic [DATA_W-1:0] m_xfer_end,
  output logic              m_xfer_rw,
  output logic [IW-1:0]     m_xfer_id,
  input  logic              s_done_valid,
  output logic              s_done_ready,
  input  logic [IW-1:0]     s_done_data,
  output logic              m_remove_req_valid,
  input  logic              m_remove_req_ready,
  output logic [IW-1:0]     m_remove_req_data
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LKUP       = 3'd1;
  localparam logic [2:0] S_LKUP_WAIT  = 3'd2;
  localparam logic [2:0] S_BACKOFF    = 3'd3;
  localparam logic [2:0] S_ALLOC      = 3'd4;
  localparam logic [2:0] S_ALLOC_WAIT = 3'd5;
  localparam logic [2:0] S_ISSUE      = 3'd6;

  logic [2:0]        state;
  logic [7:0]        bo_cnt;
  logic [DATA_W-1:0] cur_base;
  logic [DATA_W-1:0] cur_end;
  logic              cur_rw;
  logic [ID_W-1:0]   cur_id;
  logic [IW-1:0]     cur_slot;
  logic              rm_valid;
  logic [IW-1:0]     rm_idx;

  logic cmd_hs;
  logic lkup_hit;
  logic conflict_hs;
  logic xfer_hs;
  logic done_hs;

  // While reset is held every master valid is forced low and the readies
  // show their idle values, independent of the state left over from before.
  assign s_cmd_ready        = (state == S_IDLE) | ~i_rst_n;
  assign m_lkup_req_valid   = (state == S_LKUP) & i_rst_n;
  assign s_lkup_resp_ready  = (state == S_LKUP_WAIT) & i_rst_n;
  assign m_alloc_req_valid  = (state == S_ALLOC) & i_rst_n;
  assign s_alloc_resp_ready = (state == S_ALLOC_WAIT) & i_rst_n;
  assign m_xfer_valid       = (state == S_ISSUE) & i_rst_n;
  assign s_done_ready       = ~rm_valid | m_remove_req_ready | ~i_rst_n;
  assign m_remove_req_valid = rm_valid & i_rst_n;

  assign m_lkup_req_base  = cur_base;
  assign m_lkup_req_end   = cur_end;
  assign m_lkup_req_rw    = cur_rw;
  assign m_lkup_req_id    = cur_id;
  assign m_alloc_req_base = cur_base;
  assign m_alloc_req_end  = cur_end;
  assign m_alloc_req_rw   = cur_rw;
  assign m_xfer_base      = cur_base;
  assign m_xfer_end       = cur_end;
  assign m_xfer_rw        = cur_rw;
  assign m_xfer_id        = cur_slot;
  assign m_remove_req_data = rm_idx;

  assign cmd_hs      = s_cmd_valid & s_cmd_ready;
  // Responses tagged with another command's id are stale and get dropped.
  assign lkup_hit    = s_lkup_resp_valid & s_lkup_resp_ready & (s_lkup_resp_id == cur_id);
  assign conflict_hs = lkup_hit & s_lkup_resp_data;
  assign xfer_hs     = m_xfer_valid & m_xfer_ready;
  assign done_hs     = s_done_valid & s_done_ready;

  // Dispatch FSM: lookup, optional back-off and retry, allocate, issue.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      bo_cnt   <= '0;
      cur_base <= '0;
      cur_end  <= '0;
      cur_rw   <= 1'b0;
      cur_id   <= '0;
      cur_slot <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            cur_base <= s_cmd_base;
            cur_end  <= s_cmd_end;
            cur_rw   <= s_cmd_rw;
            cur_id   <= s_cmd_id;
            state    <= S_LKUP;
          end
        end
        S_LKUP: begin
          if (m_lkup_req_ready) state <= S_LKUP_WAIT;
        end
        S_LKUP_WAIT: begin
          if (conflict_hs) begin
            bo_cnt <= 8'(BACKOFF);
            state  <= S_BACKOFF;
          end else if (lkup_hit) begin
            state <= S_ALLOC;
          end
        end
        S_BACKOFF: begin
          // Counter value 1 is the last idle cycle; retry follows it.
          if (bo_cnt <= 8'd1) begin
            bo_cnt <= '0;
            state  <= S_LKUP;
          end else begin
            bo_cnt <= bo_cnt - 8'd1;
          end
        end
        S_ALLOC: begin
          if (m_alloc_req_ready) state <= S_ALLOC_WAIT;
        end
        S_ALLOC_WAIT: begin
          if (s_alloc_resp_valid) begin
            cur_slot <= s_alloc_resp_data;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_xfer_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion-to-remove register; a load and an unload can share a cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rm_valid <= 1'b0;
    end else if (done_hs) begin
      rm_valid <= 1'b1;
    end else if (m_remove_req_ready) begin
      rm_valid <= 1'b0;
    end
  end

  // Slot index payload of the remove register; qualified by rm_valid.
  always_ff @(posedge i_clk) begin
    if (done_hs) rm_idx <= s_done_data;
  end

`ifdef CX_DISPATCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] retry_cnt;
  logic [31:0] xfer_cnt;

  // Saturating retry and transfer counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      retry_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (conflict_hs) retry_cnt <= sat_inc(retry_cnt);
      if (xfer_hs)     xfer_cnt  <= sat_inc(xfer_cnt);
    end
  end

  assign o_retry_cnt = retry_cnt;
  assign o_xfer_cnt  = xfer_cnt;
`else
  logic unused_xfer_hs;
  assign unused_xfer_hs = xfer_hs;
`endif

endmodule

// File: tb/tb_cx_dma_dispatch.sv
// Scoreboard bench for cx_dma_dispatch: queue-driven peers answer the
// tracker ports; a monitor checks every output handshake against the
// expected queues, plus hold/stability and cycle-latency properties.
module tb_cx_dma_dispatch;
  localparam int BO = 4;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] e;
    logic        rw;
    logic [3:0]  id;
  } ent_t;

  typedef struct packed {
    logic [3:0] id;
    logic       c;
  } lr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_cmd_valid, s_cmd_ready, s_cmd_rw;
  logic [31:0] s_cmd_base, s_cmd_end;
  logic [3:0]  s_cmd_id;
  logic        m_lkup_req_valid, m_lkup_req_ready, m_lkup_req_rw;
  logic [31:0] m_lkup_req_base, m_lkup_req_end;
  logic [3:0]  m_lkup_req_id;
  logic        s_lkup_resp_valid, s_lkup_resp_ready, s_lkup_resp_data;
  logic [3:0]  s_lkup_resp_id;
  logic        m_alloc_req_valid, m_alloc_req_ready, m_alloc_req_rw;
  logic [31:0] m_alloc_req_base, m_alloc_req_end;
  logic        s_alloc_resp_valid, s_alloc_resp_ready;
  logic [2:0]  s_alloc_resp_data;
  logic        m_xfer_valid, m_xfer_ready, m_xfer_rw;
  logic [31:0] m_xfer_base, m_xfer_end;
  logic [2:0]  m_xfer_id;
  logic        s_done_valid, s_done_ready;
  logic [2:0]  s_done_data;
  logic        m_remove_req_valid, m_remove_req_ready;
  logic [2:0]  m_remove_req_data;
`ifdef CX_DISPATCH_STATS_EN
  logic [31:0] o_retry_cnt, o_xfer_cnt;
`endif

  cx_dma_dispatch #(.DEPTH(8), .BACKOFF(BO), .DATA_W(32), .ID_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef CX_DISPATCH_STATS_EN
    .o_retry_cnt(o_retry_cnt), .o_xfer_cnt(o_xfer_cnt),
`endif
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_base(s_cmd_base),
    .s_cmd_end(s_cmd_end), .s_cmd_rw(s_cmd_rw), .s_cmd_id(s_cmd_id),
    .m_lkup_req_valid(m_lkup_req_valid), .m_lkup_req_ready(m_lkup_req_ready),
    .m_lkup_req_base(m_lkup_req_base), .m_lkup_req_end(m_lkup_req_end),
    .m_lkup_req_rw(m_lkup_req_rw), .m_lkup_req_id(m_lkup_req_id),
    .s_lkup_resp_valid(s_lkup_resp_valid), .s_lkup_resp_ready(s_lkup_resp_ready),
    .s_lkup_resp_data(s_lkup_resp_data), .s_lkup_resp_id(s_lkup_resp_id),
    .m_alloc_req_valid(m_alloc_req_valid), .m_alloc_req_ready(m_alloc_req_ready),
    .m_alloc_req_base(m_alloc_req_base), .m_alloc_req_end(m_alloc_req_end),
    .m_alloc_req_rw(m_alloc_req_rw),
    .s_alloc_resp_valid(s_alloc_resp_valid), .s_alloc_resp_ready(s_alloc_resp_ready),
    .s_alloc_resp_data(s_alloc_resp_data),
    .m_xfer_valid(m_xfer_valid), .m_xfer_ready(m_xfer_ready), .m_xfer_base(m_xfer_base),
    .m_xfer_end(m_xfer_end), .m_xfer_rw(m_xfer_rw), .m_xfer_id(m_xfer_id),
    .s_done_valid(s_done_valid), .s_done_ready(s_done_ready), .s_done_data(s_done_data),
    .m_remove_req_valid(m_remove_req_valid), .m_remove_req_ready(m_remove_req_ready),
    .m_remove_req_data(m_remove_req_data)
  );

  ent_t        cmd_q[$], exp_lk[$], exp_al[$], exp_xf[$];
  lr_t         lr_q[$];
  logic [2:0]  ar_q[$], dn_q[$], exp_rm[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0, conf_cyc = 0, xf_cyc = 0;
  int xf_cnt = 0, al_cnt = 0, rm_cnt = 0, dn_cnt = 0;
  int rm_cyc_a[16];
  int dn_cyc_a[16];
  logic acc_pend = 1'b0, conf_pend = 1'b0;
  logic [3:0] last_lk_id = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred=%0d required=%0d", nm, 1, 0);
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0: return xf_cnt;
      1: return al_cnt;
      2: return rm_cnt;
      default: return dn_cnt;
    endcase
  endfunction

  task automatic wait_ge(input int sel, input int target, input string nm);
    int n = 0;
    while (cnt_of(sel) < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) fail_now(nm);
  endtask

  task automatic wait_valid(input int sel, input string nm);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if ((sel == 0 && m_lkup_req_valid) || (sel == 1 && m_xfer_valid)) break;
      n++;
    end
    if (n >= 100) fail_now(nm);
  endtask

  // Peer models: present queued command / responses / completions.
  initial begin : peers
    logic c_hs, l_hs, a_hs, d_hs;
    ent_t te;
    lr_t tl;
    logic [2:0] ts;
    s_cmd_valid = 0; s_cmd_base = 0; s_cmd_end = 0; s_cmd_rw = 0; s_cmd_id = 0;
    s_lkup_resp_valid = 0; s_lkup_resp_data = 0; s_lkup_resp_id = 0;
    s_alloc_resp_valid = 0; s_alloc_resp_data = 0;
    s_done_valid = 0; s_done_data = 0;
    forever begin
      @(negedge clk);
      c_hs = s_cmd_valid && s_cmd_ready;
      l_hs = s_lkup_resp_valid && s_lkup_resp_ready;
      a_hs = s_alloc_resp_valid && s_alloc_resp_ready;
      d_hs = s_done_valid && s_done_ready;
      @(posedge clk);
      #1;
      if (c_hs && cmd_q.size() > 0) te = cmd_q.pop_front();
      if (l_hs && lr_q.size() > 0) tl = lr_q.pop_front();
      if (a_hs && ar_q.size() > 0) ts = ar_q.pop_front();
      if (d_hs && dn_q.size() > 0) ts = dn_q.pop_front();
      s_cmd_valid = (cmd_q.size() > 0);
      if (cmd_q.size() > 0) begin
        s_cmd_base = cmd_q[0].b; s_cmd_end = cmd_q[0].e;
        s_cmd_rw = cmd_q[0].rw; s_cmd_id = cmd_q[0].id;
      end
      s_lkup_resp_valid = (lr_q.size() > 0);
      if (lr_q.size() > 0) begin
        s_lkup_resp_id = lr_q[0].id; s_lkup_resp_data = lr_q[0].c;
      end
      s_alloc_resp_valid = (ar_q.size() > 0);
      if (ar_q.size() > 0) s_alloc_resp_data = ar_q[0];
      s_done_valid = (dn_q.size() > 0);
      if (dn_q.size() > 0) s_done_data = dn_q[0];
    end
  end

  // Monitor: scoreboard pops, hold checks and latency checks.
  initial begin : mon
    logic plv, plr, pxv, pxr;
    ent_t pl, px, ex;
    logic [2:0] r;
    plv = 0; plr = 0; pxv = 0; pxr = 0; pl = '0; px = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        plv = 0; pxv = 0; acc_pend = 0; conf_pend = 0;
      end else begin
        if (s_cmd_valid && s_cmd_ready) begin acc_cyc = cyc; acc_pend = 1; end
        if (plv && !plr) begin
          chk("lkup_hold_valid", 64'(m_lkup_req_valid), 64'(1));
          chk("lkup_hold_addr", {m_lkup_req_base, m_lkup_req_end}, {pl.b, pl.e});
          chk("lkup_hold_tag", 64'({m_lkup_req_rw, m_lkup_req_id}), 64'({pl.rw, pl.id}));
        end
        if (m_lkup_req_valid && !plv) begin
          if (acc_pend) chk("lkup_after_accept", 64'(cyc - acc_cyc), 64'(1));
          if (conf_pend) chk("retry_gap", 64'(cyc - conf_cyc), 64'(BO + 1));
          acc_pend = 0; conf_pend = 0;
        end
        if (m_lkup_req_valid && m_lkup_req_ready) begin
          last_lk_id = m_lkup_req_id;
          if (exp_lk.size() == 0) fail_now("lkup_extra");
          else begin
            ex = exp_lk.pop_front();
            chk("lkup_addr", {m_lkup_req_base, m_lkup_req_end}, {ex.b, ex.e});
            chk("lkup_tag", 64'({m_lkup_req_rw, m_lkup_req_id}), 64'({ex.rw, ex.id}));
          end
        end
        plv = m_lkup_req_valid; plr = m_lkup_req_ready;
        pl = '{b: m_lkup_req_base, e: m_lkup_req_end, rw: m_lkup_req_rw, id: m_lkup_req_id};
        if (s_lkup_resp_valid && s_lkup_resp_ready && s_lkup_resp_data &&
            s_lkup_resp_id == last_lk_id) begin
          conf_pend = 1; conf_cyc = cyc;
        end
        if (m_alloc_req_valid && m_alloc_req_ready) begin
          al_cnt++;
          if (exp_al.size() == 0) fail_now("alloc_extra");
          else begin
            ex = exp_al.pop_front();
            chk("alloc_addr", {m_alloc_req_base, m_alloc_req_end}, {ex.b, ex.e});
            chk("alloc_rw", 64'(m_alloc_req_rw), 64'(ex.rw));
          end
        end
        if (pxv && !pxr) begin
          chk("xfer_hold_valid", 64'(m_xfer_valid), 64'(1));
          chk("xfer_hold_addr", {m_xfer_base, m_xfer_end}, {px.b, px.e});
          chk("xfer_hold_tag", 64'({m_xfer_rw, 1'b0, m_xfer_id}), 64'({px.rw, px.id}));
        end
        if (m_xfer_valid && m_xfer_ready) begin
          xf_cnt++; xf_cyc = cyc;
          if (exp_xf.size() == 0) fail_now("xfer_extra");
          else begin
            ex = exp_xf.pop_front();
            chk("xfer_addr", {m_xfer_base, m_xfer_end}, {ex.b, ex.e});
            chk("xfer_tag", 64'({m_xfer_rw, 1'b0, m_xfer_id}), 64'({ex.rw, ex.id}));
          end
        end
        pxv = m_xfer_valid; pxr = m_xfer_ready;
        px = '{b: m_xfer_base, e: m_xfer_end, rw: m_xfer_rw, id: {1'b0, m_xfer_id}};
        if (s_done_valid && s_done_ready) begin
          dn_cyc_a[dn_cnt % 16] = cyc; dn_cnt++;
        end
        if (m_remove_req_valid && m_remove_req_ready) begin
          rm_cyc_a[rm_cnt % 16] = cyc; rm_cnt++;
          if (exp_rm.size() == 0) fail_now("remove_extra");
          else begin
            r = exp_rm.pop_front();
            chk("remove_idx", 64'(m_remove_req_data), 64'(r));
          end
        end
      end
    end
  end

  task automatic push_cmd(input ent_t c, input logic [2:0] slot);
    ent_t x;
    x = c;
    x.id = {1'b0, slot};
    exp_lk.push_back(c);
    exp_al.push_back(c);
    exp_xf.push_back(x);
    cmd_q.push_back(c);
  endtask

  // Directed scenarios.
  initial begin : main
    ent_t c;
    rst_n = 0;
    m_lkup_req_ready = 1; m_alloc_req_ready = 1; m_xfer_ready = 1; m_remove_req_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(s_cmd_ready), 64'(1));
    chk("rst_master_valids", 64'({m_lkup_req_valid, m_alloc_req_valid, m_xfer_valid,
        m_remove_req_valid}), 64'(0));
    chk("rst_slave_readies", 64'({s_lkup_resp_ready, s_alloc_resp_ready, s_done_ready}), 64'(1));
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(s_cmd_ready), 64'(1));
    chk("idle_master_valids", 64'({m_lkup_req_valid, m_alloc_req_valid, m_xfer_valid,
        m_remove_req_valid}), 64'(0));

    // Single conflict-free command, slot 2, 5 cycles accept -> xfer.
    c = '{b: 32'h1000, e: 32'h10FF, rw: 1'b1, id: 4'd3};
    lr_q.push_back('{id: 4'd3, c: 1'b0});
    ar_q.push_back(3'd2);
    push_cmd(c, 3'd2);
    wait_ge(0, 1, "t1_xfer_timeout");
    chk("t1_accept_to_xfer", 64'(xf_cyc - acc_cyc), 64'(5));
    repeat (3) @(posedge clk);

    // Two conflicts, then clear.
    @(negedge clk);
    c = '{b: 32'h2000, e: 32'h2FFF, rw: 1'b0, id: 4'd5};
    lr_q.push_back('{id: 4'd5, c: 1'b1});
    lr_q.push_back('{id: 4'd5, c: 1'b1});
    lr_q.push_back('{id: 4'd5, c: 1'b0});
    ar_q.push_back(3'd3);
    exp_lk.push_back(c); exp_lk.push_back(c);
    push_cmd(c, 3'd3);
    wait_ge(0, 2, "t2_xfer_timeout");
`ifdef CX_DISPATCH_STATS_EN
    @(negedge clk);
    chk("t2_retry_cnt", 64'(o_retry_cnt), 64'(2));
    chk("t2_xfer_cnt", 64'(o_xfer_cnt), 64'(2));
`endif
    repeat (3) @(posedge clk);

    // Back-pressure on lookup and transfer for 7 cycles each.
    @(posedge clk); #1;
    m_lkup_req_ready = 0; m_xfer_ready = 0;
    @(negedge clk);
    c = '{b: 32'h4000, e: 32'h4FFF, rw: 1'b0, id: 4'd6};
    lr_q.push_back('{id: 4'd6, c: 1'b0});
    ar_q.push_back(3'd4);
    push_cmd(c, 3'd4);
    wait_valid(0, "t3_lkup_valid_timeout");
    repeat (7) @(posedge clk);
    #1 m_lkup_req_ready = 1;
    wait_valid(1, "t3_xfer_valid_timeout");
    repeat (7) @(posedge clk);
    #1 m_xfer_ready = 1;
    wait_ge(0, 3, "t3_xfer_timeout");
    repeat (3) @(posedge clk);

    // Back-to-back completions 1,4,6.
    @(negedge clk);
    dn_q.push_back(3'd1); dn_q.push_back(3'd4); dn_q.push_back(3'd6);
    exp_rm.push_back(3'd1); exp_rm.push_back(3'd4); exp_rm.push_back(3'd6);
    wait_ge(2, 3, "t4_remove_timeout");
    chk("t4_done_to_remove", 64'(rm_cyc_a[0] - dn_cyc_a[0]), 64'(1));
    chk("t4_remove_gap1", 64'(rm_cyc_a[1] - rm_cyc_a[0]), 64'(1));
    chk("t4_remove_gap2", 64'(rm_cyc_a[2] - rm_cyc_a[1]), 64'(1));
    repeat (2) @(posedge clk);

    // Remove port stalled: completions must back up in order.
    @(posedge clk); #1 m_remove_req_ready = 0;
    @(negedge clk);
    dn_q.push_back(3'd2); dn_q.push_back(3'd5); dn_q.push_back(3'd7);
    exp_rm.push_back(3'd2); exp_rm.push_back(3'd5); exp_rm.push_back(3'd7);
    wait_ge(3, 4, "t4b_done_timeout");
    @(negedge clk);
    chk("t4b_done_ready_drop", 64'(s_done_ready), 64'(0));
    chk("t4b_remove_valid", 64'(m_remove_req_valid), 64'(1));
    chk("t4b_remove_data", 64'(m_remove_req_data), 64'(2));
    repeat (2) @(posedge clk);
    #1 m_remove_req_ready = 1;
    wait_ge(2, 6, "t4b_remove_timeout");
    repeat (3) @(posedge clk);

    // Stale lookup response (id 7, conflict) ignored; id 3 clear proceeds.
    @(negedge clk);
    c = '{b: 32'h3000, e: 32'h30FF, rw: 1'b1, id: 4'd3};
    lr_q.push_back('{id: 4'd7, c: 1'b1});
    lr_q.push_back('{id: 4'd3, c: 1'b0});
    ar_q.push_back(3'd5);
    push_cmd(c, 3'd5);
    wait_ge(0, 4, "t5_xfer_timeout");
    repeat (3) @(posedge clk);

    // Reset while waiting on the allocation response.
    @(negedge clk);
    c = '{b: 32'h6000, e: 32'h60FF, rw: 1'b0, id: 4'd2};
    lr_q.push_back('{id: 4'd2, c: 1'b0});
    exp_lk.push_back(c); exp_al.push_back(c); cmd_q.push_back(c);
    wait_ge(1, 5, "t6_alloc_timeout");
    #1;
    chk("t6_in_alloc_wait", 64'(s_alloc_resp_ready), 64'(1));
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_valids", 64'({m_lkup_req_valid, m_alloc_req_valid, m_xfer_valid}), 64'(0));
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("t6_post_cmd_ready", 64'(s_cmd_ready), 64'(1));
    chk("t6_post_valids", 64'({m_lkup_req_valid, m_alloc_req_valid, m_xfer_valid,
        m_remove_req_valid}), 64'(0));
    chk("t6_post_alloc_ready", 64'(s_alloc_resp_ready), 64'(0));
`ifdef CX_DISPATCH_STATS_EN
    chk("t6_stats_cleared", 64'({o_retry_cnt, o_xfer_cnt}), 64'(0));
`endif
    c = '{b: 32'h5000, e: 32'h50FF, rw: 1'b1, id: 4'd1};
    lr_q.push_back('{id: 4'd1, c: 1'b0});
    ar_q.push_back(3'd0);
    push_cmd(c, 3'd0);
    wait_ge(0, 5, "t6_xfer_timeout");
    repeat (4) @(posedge clk);

    chk("left_lkup", 64'(exp_lk.size()), 64'(0));
    chk("left_alloc", 64'(exp_al.size()), 64'(0));
    chk("left_xfer", 64'(exp_xf.size()), 64'(0));
    chk("left_remove", 64'(exp_rm.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
